// File: rtl/vector_mul_sequencer.sv
// vector_mul_sequencer: a multi-cycle vector fixed-point multiplier.
// One LANES-wide operand pair is accepted per transaction. PHYS_LANES
// multipliers are time-shared across all lanes, NBEATS = LANES/PHYS_LANES
// beats in total. The packed result is then held on a valid/ready output.
//
// Build option: define VMUL_SEQ_SAT_EN to saturate each lane result to all
// ones when the scaled product does not fit in DATA_WIDTH bits. Without it
// the scaled product is truncated. Result timing is the same in both builds.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | in_ready=1, waiting for an operand pair
// S_COMPUTE | one beat per cycle, PHYS_LANES lanes written to out per beat
// S_DONE    | out_valid=1, out held until out_ready

module vector_mul_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 8,
   parameter int PHYS_LANES = 2,
   parameter int FRAC_BITS  = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES*DATA_WIDTH-1:0] operand1,
   input  logic [LANES*DATA_WIDTH-1:0] operand2,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*DATA_WIDTH-1:0] out,
   output logic                        busy
);

   localparam int NBEATS = LANES / PHYS_LANES;
   localparam int BEAT_W = $clog2(NBEATS + 1);
   localparam int PROD_W = 2 * DATA_WIDTH;
   localparam int VEC_W  = LANES * DATA_WIDTH;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

   // Uneven lane sharing would leave lanes uncomputed; refuse to elaborate.
   if (PHYS_LANES < 1 || (LANES % PHYS_LANES) != 0) begin : g_bad_phys_lanes
      $error("vector_mul_sequencer: PHYS_LANES must divide LANES");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [BEAT_W-1:0]   beat;
   logic [VEC_W-1:0]    op_a;
   logic [VEC_W-1:0]    op_b;
   logic [VEC_W-1:0]    out_r;
   logic [DATA_WIDTH-1:0] lane_res [PHYS_LANES];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and handshake outputs; all outputs decode directly from state.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               state_nx = S_COMPUTE;
            end
         end
         S_COMPUTE: begin
            if (beat == LAST_BEAT) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
            busy     = 1'b0;
         end
      endcase
   end

   // Physical multipliers: each picks its lane of the current beat from the
   // latched operands, multiplies at full width and applies the fixed-point shift.
   for (genvar j = 0; j < PHYS_LANES; j++) begin : g_mul
      logic [DATA_WIDTH-1:0] a_sel;
      logic [DATA_WIDTH-1:0] b_sel;
      logic [PROD_W-1:0]     prod;

      assign a_sel = op_a[(int'(beat) * PHYS_LANES + j) * DATA_WIDTH +: DATA_WIDTH];
      assign b_sel = op_b[(int'(beat) * PHYS_LANES + j) * DATA_WIDTH +: DATA_WIDTH];
      assign prod  = {{DATA_WIDTH{1'b0}}, a_sel} * {{DATA_WIDTH{1'b0}}, b_sel};

`ifdef VMUL_SEQ_SAT_EN
      logic [PROD_W-1:0] q;
      // A shift of PROD_W or more leaves zero, so large FRAC_BITS needs no special case.
      assign q = prod >> FRAC_BITS;
      assign lane_res[j] = (q[PROD_W-1:DATA_WIDTH] != '0) ? {DATA_WIDTH{1'b1}}
                                                          : q[DATA_WIDTH-1:0];
`else
      // A shift of PROD_W or more leaves zero, so large FRAC_BITS needs no special case.
      assign lane_res[j] = DATA_WIDTH'(prod >> FRAC_BITS);
`endif
   end

   // Operand capture, beat counting and lane write-back into the result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat  <= '0;
         op_a  <= '0;
         op_b  <= '0;
         out_r <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_a <= operand1;
                  op_b <= operand2;
                  beat <= '0;
               end
            end
            S_COMPUTE: begin
               for (int j = 0; j < PHYS_LANES; j++) begin
                  out_r[(int'(beat) * PHYS_LANES + j) * DATA_WIDTH +: DATA_WIDTH] <= lane_res[j];
               end
               beat <= beat + BEAT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign out = out_r;

endmodule

// File: tb/tb_vector_mul_sequencer.sv
// Directed bench for vector_mul_sequencer. Four instances share clock, reset,
// operands and out_ready; each has its own in_valid so only one runs at a time:
//   0: defaults   1: FRAC_BITS=0   2: PHYS_LANES=8   3: PHYS_LANES=1
// Latency is counted in rising edges from the cycle in_valid is presented,
// the accepting edge being the first.

module tb_vector_mul_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [3:0]  out_valid;
   logic [3:0]  busy;
   logic [63:0] operand1;
   logic [63:0] operand2;
   logic        out_ready;
   logic [63:0] out_v [4];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vector_mul_sequencer u_def (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .operand1(operand1), .operand2(operand2), .out_valid(out_valid[0]),
      .out_ready(out_ready), .out(out_v[0]), .busy(busy[0]));

   vector_mul_sequencer #(.FRAC_BITS(0)) u_f0 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .operand1(operand1), .operand2(operand2), .out_valid(out_valid[1]),
      .out_ready(out_ready), .out(out_v[1]), .busy(busy[1]));

   vector_mul_sequencer #(.PHYS_LANES(8)) u_p8 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .operand1(operand1), .operand2(operand2), .out_valid(out_valid[2]),
      .out_ready(out_ready), .out(out_v[2]), .busy(busy[2]));

   vector_mul_sequencer #(.PHYS_LANES(1)) u_p1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
      .operand1(operand1), .operand2(operand2), .out_valid(out_valid[3]),
      .out_ready(out_ready), .out(out_v[3]), .busy(busy[3]));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one operand pair to instance k, wait for the result, check
   // latency and value, then hand it off with a one-cycle out_ready.
   task automatic run(input int k, input logic [63:0] a, input logic [63:0] b,
                      input int exp_lat, input logic [63:0] exp_out, input string tag);
      int cnt;
      operand1 = a;
      operand2 = b;
      in_valid[k] = 1'b1;
      chk({tag, " in_ready idle"}, 64'(in_ready[k]), 64'd1);
      step();
      in_valid[k] = 1'b0;
      cnt = 1;
      chk({tag, " busy"}, 64'(busy[k]), 64'd1);
      while (!out_valid[k] && cnt < 50) begin
         step();
         cnt++;
      end
      chk({tag, " latency"}, 64'(cnt), 64'(exp_lat));
      chk({tag, " out"}, out_v[k], exp_out);
      chk({tag, " in_ready done"}, 64'(in_ready[k]), 64'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, " out_valid drop"}, 64'(out_valid[k]), 64'd0);
      chk({tag, " in_ready back"}, 64'(in_ready[k]), 64'd1);
   endtask

   initial begin
      logic [63:0] held;
      int          cnt;
      logic [63:0] f0_exp;

      rst       = 1'b1;
      in_valid  = '0;
      out_ready = 1'b0;
      operand1  = '0;
      operand2  = '0;
      step();
      step();
      rst = 1'b0;
      chk("rst in_ready", 64'(in_ready), 64'hF);
      chk("rst out_valid", 64'(out_valid), 64'h0);
      chk("rst busy", 64'(busy), 64'h0);
      chk("rst out", out_v[0], 64'h0);

      // 0xFF*0xFF = 65025, >>10 = 63
      run(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5,
          64'h3F3F_3F3F_3F3F_3F3F, "ones");

      // a[i] = 32*(i+1) mod 256, b = 64: lane = a/16 -> 2,4,...,14,0
      run(0, 64'h00E0_C0A0_8060_4020, 64'h4040_4040_4040_4040, 5,
          64'h000E_0C0A_0806_0402, "lanes");

      // Backpressure: 0x10*0xC0 = 3072 >> 10 = 3 per lane.
      operand1 = 64'h1010_1010_1010_1010;
      operand2 = 64'hC0C0_C0C0_C0C0_C0C0;
      in_valid[0] = 1'b1;
      step();
      in_valid[0] = 1'b0;
      cnt = 1;
      while (!out_valid[0] && cnt < 50) begin
         step();
         cnt++;
      end
      chk("bp latency", 64'(cnt), 64'd5);
      held = out_v[0];
      chk("bp out", held, 64'h0303_0303_0303_0303);
      // Next operands wait on in_valid while the result sits unaccepted.
      operand1 = 64'hFFFF_FFFF_FFFF_FFFF;
      operand2 = 64'h8080_8080_8080_8080;
      in_valid[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp hold valid", 64'(out_valid[0]), 64'd1);
         chk("bp hold out", out_v[0], 64'h0303_0303_0303_0303);
         chk("bp hold in_ready", 64'(in_ready[0]), 64'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("bp handoff valid", 64'(out_valid[0]), 64'd0);
      chk("bp handoff in_ready", 64'(in_ready[0]), 64'd1);
      chk("bp out kept", out_v[0], 64'h0303_0303_0303_0303);
      step();
      in_valid[0] = 1'b0;
      chk("bp accepted", 64'(busy[0]), 64'd1);
      cnt = 1;
      while (!out_valid[0] && cnt < 50) begin
         step();
         cnt++;
      end
      chk("bp2 latency", 64'(cnt), 64'd5);
      // 0xFF*0x80 = 32640 >> 10 = 31
      chk("bp2 out", out_v[0], 64'h1F1F_1F1F_1F1F_1F1F);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Reset in beat 2 of COMPUTE abandons the transaction.
      operand1 = 64'h4444_4444_4444_4444;
      operand2 = 64'h4444_4444_4444_4444;
      in_valid[0] = 1'b1;
      step();
      in_valid[0] = 1'b0;
      step();
      step();
      chk("mid busy", 64'(busy[0]), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid rst out_valid", 64'(out_valid[0]), 64'd0);
      chk("mid rst out", out_v[0], 64'h0);
      chk("mid rst in_ready", 64'(in_ready[0]), 64'd1);
      chk("mid rst busy", 64'(busy[0]), 64'd0);
      // 0x80*0x80 = 16384 >> 10 = 16
      run(0, 64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080, 5,
          64'h1010_1010_1010_1010, "post rst");

      // FRAC_BITS=0: 0xFF*2 = 0x1FE does not fit in 8 bits.
`ifdef VMUL_SEQ_SAT_EN
      f0_exp = 64'hFFFF_FFFF_FFFF_FFFF;
`else
      f0_exp = 64'hFEFE_FEFE_FEFE_FEFE;
`endif
      run(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0202_0202_0202_0202, 5, f0_exp, "f0 ovf");
      run(1, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0202_0202_0202_0202, 5,
          64'h1E1E_1E1E_1E1E_1E1E, "f0 fit");

      // Other lane-sharing factors give the same results with their own latency.
      run(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2,
          64'h3F3F_3F3F_3F3F_3F3F, "p8 ones");
      run(2, 64'h00E0_C0A0_8060_4020, 64'h4040_4040_4040_4040, 2,
          64'h000E_0C0A_0806_0402, "p8 lanes");
      run(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 9,
          64'h3F3F_3F3F_3F3F_3F3F, "p1 ones");
      run(3, 64'h00E0_C0A0_8060_4020, 64'h4040_4040_4040_4040, 9,
          64'h000E_0C0A_0806_0402, "p1 lanes");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
